// File: rtl/encoder_4x2_queued.sv
// encoder_4x2_queued: sequential 4-to-2 encoder, the inverse of the 2x4
// active-low decoder. Active-low requests are captured into sticky pending
// bits and drained one 2-bit code {A,B} at a time over a valid/ready handshake.
// Optional feature: define ENCODER_ROUND_ROBIN_EN for rotating priority;
// otherwise fixed priority 3 > 2 > 1 > 0.
module encoder_4x2_queued (
    input  logic       clock,
    input  logic       reset_b,
    input  logic [0:3] req_n,
    input  logic       enable_n,
    input  logic       ready,
    output logic       A,
    output logic       B,
    output logic       valid,
    output logic       busy
);

    logic [0:3] pend;
    logic [0:3] clr;
    logic [1:0] sel;
    logic       load;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [1:0] ptr;
    logic [1:0] idx;

    // Rotating search from ptr+1 up to ptr; the lowest offset that is pending wins.
    always_comb begin
        sel = 2'd0;
        idx = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (pend[idx]) begin
                sel = idx;
            end
        end
    end

    // Remember the last granted index so the next search starts just past it.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            ptr <= 2'd3;
        end else if (load) begin
            ptr <= sel;
        end
    end
`else
    // Fixed priority: highest pending index wins.
    always_comb begin
        sel = 2'd0;
        if (pend[3]) begin
            sel = 2'd3;
        end else if (pend[2]) begin
            sel = 2'd2;
        end else if (pend[1]) begin
            sel = 2'd1;
        end else begin
            sel = 2'd0;
        end
    end
`endif

    // A new code is presented whenever something is pending and the output slot is free or being consumed.
    assign load = (pend != 4'b0000) && (!valid || ready);
    assign busy = (pend != 4'b0000) || valid;

    // One-hot clear of the index being granted this cycle.
    always_comb begin
        clr = 4'b0000;
        if (load) begin
            clr[sel] = 1'b1;
        end
    end

    // Sticky pending bits; a same-cycle request re-sets a bit being cleared.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            pend <= 4'b0000;
        end else begin
            pend <= (pend & ~clr) | (~req_n & {4{~enable_n}});
        end
    end

    // Output code register: load a new code, retire a consumed one, or hold under backpressure.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            valid <= 1'b0;
            A     <= 1'b0;
            B     <= 1'b0;
        end else if (load) begin
            {A, B} <= sel;
            valid  <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: doc/encoder_4x2_queued.md
# encoder_4x2_queued

Sequential 4-to-2 encoder that is the inverse of the team's 2x4 active-low decoder. It samples four active-low request lines, holds every asserted request as a sticky pending bit, and emits one 2-bit index (A = MSB, B = LSB) per accepted transfer over a valid/ready handshake. Typical use: collecting decoded select or interrupt lines back into a binary code for a downstream sequencer.

## Interface
- No parameters; width fixed at 4 requests / 2-bit code.
- clock  input  1  rising-edge clock; sole clock domain.
- reset_b  input  1  asynchronous, active-low reset.
- req_n  input  [0:3]  active-low request lines; bit i low = request for index i.
- enable_n  input  1  active-low capture enable; high blocks new captures only.
- ready  input  1  downstream accepts the current code when high with valid high.
- A  output  1  code MSB (registered).
- B  output  1  code LSB (registered).
- valid  output  1  {A,B} holds an unconsumed code.
- busy  output  1  combinational: (pending != 0) | valid.

## Operation
- Pending register P[0:3]: at each edge, P[i] <= (P[i] & ~clr[i]) | (~req_n[i] & ~enable_n). Set wins over same-cycle clear, so a request re-asserted on the cycle its index is granted stays pending.
- Load condition: load = (P != 0) & (~valid | ready). Selection uses the registered P only, never same-cycle req_n.
- On load: {A,B} <= selected index, valid <= 1, clr[sel] = 1.
- If valid & ready & P == 0: valid <= 0; A, B hold last value.
- If valid & ~ready: A, B, valid hold; P keeps accumulating.
- Fixed priority (default): index 3 highest, 0 lowest (3 -> A=1,B=1; 0 -> A=0,B=0).
- Requests are level-sampled; holding req_n[i] low for N cycles yields one pending bit, re-set after each grant while still low.
- enable_n high: no captures; existing P continues draining.
- Reset (reset_b low, any time, asynchronous): P = 0, valid = 0, A = 0, B = 0, round-robin pointer = 3. Requests in flight are discarded; first capture is the first edge after reset_b rises with req_n low.

## Timing
- req_n[i] low at edge k -> P[i] = 1 after edge k -> valid = 1 with code i after edge k+1 (latency 2 cycles, empty queue).
- Back-to-back throughput: one code per cycle while ready stays high and P != 0.
- Handshake transfer occurs on the edge where valid & ready are both 1; the next code appears on that same edge if P != 0 (no bubble).
- Code stability: A, B, valid must not change while valid & ~ready.
- busy deasserts in the cycle after the final transfer with P == 0.

## Configuration
- ENCODER_ROUND_ROBIN_EN defined: rotating priority. Pointer L (2 bits, reset 3) records last granted index; search order L+1, L+2, L+3, L (mod 4); L <= sel on each load.
- Not defined: fixed priority 3 > 2 > 1 > 0; no pointer register.

## Test plan
- Reset mid-stream: req_n = 4'b0000 for 3 cycles, ready = 0, then reset_b low -> A = 0, B = 0, valid = 0, busy = 0 immediately (before next edge).
- Single request: req_n[2] low for one cycle, ready = 1 -> valid = 1, A = 1, B = 0 two edges later, for exactly one cycle.
- All four pulsed once together, ready = 1, fixed priority -> codes 3, 2, 1, 0 on four consecutive cycles, then valid = 0.
- Backpressure: codes 3 and 1 pending, ready = 0 for 5 cycles -> A = 1, B = 1, valid = 1 held; ready = 1 -> code 1 next cycle, then idle.
- Gating: enable_n = 1 with req_n = 4'b0000 -> P stays 0, valid never rises; enable_n = 0 -> code 3 two edges later.
- ENCODER_ROUND_ROBIN_EN: req_n held at 4'b0000, ready = 1 -> codes 0, 1, 2, 3, 0, 1 in order; without macro -> 3 every cycle.
